// File: rtl/vpi_mem_responder_pkg.sv
// Shared constants and types for the VPI-side memory responder.
// Default widths, FSM state encoding and the out-of-range response pattern.
package vpi_mem_responder_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 31;
    localparam int DEF_TID_WIDTH  = 16;
    localparam int DEF_MEM_AW     = 10;
    localparam int DEF_REQ_WIDTH  = 1 + DEF_ADDR_WIDTH + DEF_DATA_WIDTH + DEF_TID_WIDTH;
    localparam int DEF_RSP_WIDTH  = DEF_TID_WIDTH + DEF_DATA_WIDTH;

    localparam logic [31:0] OOR_PATTERN = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/vpi_mem_responder_if.sv
// Request-FIFO read side and serve-FIFO write side seen by the responder.
// master = responder, slave = the FIFO pair it talks to.
interface vpi_mem_responder_if
    import vpi_mem_responder_pkg::*;
#(
    parameter int REQ_WIDTH = DEF_REQ_WIDTH,
    parameter int RSP_WIDTH = DEF_RSP_WIDTH
);

    logic [REQ_WIDTH-1:0] req_data;
    logic                 req_empty;
    logic                 req_rd_en;
    logic [RSP_WIDTH-1:0] rsp_data;
    logic                 rsp_full;
    logic                 rsp_wr_en;

    modport master (
        input  req_data,
        input  req_empty,
        input  rsp_full,
        output req_rd_en,
        output rsp_data,
        output rsp_wr_en
    );

    modport slave (
        output req_data,
        output req_empty,
        output rsp_full,
        input  req_rd_en,
        input  rsp_data,
        input  rsp_wr_en
    );

endinterface

// File: rtl/vpi_word_ram.sv
// Single-port word memory: synchronous write, registered synchronous read, no reset.
// Read data only updates on a read access, so it holds while the caller uses it.
module vpi_word_ram
    import vpi_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int AW         = DEF_MEM_AW
) (
    input  logic                  clk,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**AW];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/vpi_mem_responder.sv
// Pops one request at a time from the request FIFO, executes it against a local
// word memory and pushes exactly one {TID, data} response into the serve FIFO.
module vpi_mem_responder
    import vpi_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TID_WIDTH  = DEF_TID_WIDTH,
    parameter int MEM_AW     = DEF_MEM_AW
) (
    input  logic                      clk,
    input  logic                      rst,
    vpi_mem_responder_if.master       bus,
    output logic                      busy,
    output logic [31:0]               req_count,
    output logic [31:0]               wr_count
);

    localparam int DATA_MSB = DATA_WIDTH - 1;
    localparam int ADDR_LSB = DATA_WIDTH;
    localparam int ADDR_MSB = ADDR_LSB + ADDR_WIDTH - 1;
    localparam int FLAG_BIT = ADDR_MSB + 1;
    localparam int TID_LSB  = FLAG_BIT + 1;
    localparam int TID_MSB  = TID_LSB + TID_WIDTH - 1;

    state_t                  r_state;
    state_t                  w_next;
    logic                    w_reqRdEn;
    logic                    w_rspWrEn;

    logic [TID_WIDTH-1:0]    r_tid;
    logic                    r_flag;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [DATA_WIDTH-1:0]   r_rspWord;
    logic                    r_rspFromRam;
    logic [31:0]             r_reqCount;
    logic [31:0]             r_wrCount;

    logic                    w_inRange;
    logic                    w_ramEn;
    logic                    w_ramWe;
    logic [DATA_WIDTH-1:0]   w_ramRdata;

    assign w_inRange = (r_addr[ADDR_WIDTH-1:MEM_AW] == '0);
    assign w_ramEn   = rst && (r_state == ST_EXEC) && w_inRange;
    assign w_ramWe   = w_ramEn && r_flag;

    vpi_word_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (MEM_AW)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ramEn),
        .i_we    (w_ramWe),
        .i_addr  (r_addr[MEM_AW-1:0]),
        .i_wdata (r_data),
        .o_rdata (w_ramRdata)
    );

    always_comb begin
        w_next    = r_state;
        w_reqRdEn = 1'b0;
        w_rspWrEn = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!bus.req_empty) begin
                    w_reqRdEn = 1'b1;
                    w_next    = ST_FETCH;
                end
            end
            ST_FETCH: w_next = ST_EXEC;
            ST_EXEC:  w_next = ST_RESP;
            ST_RESP: begin
                if (!bus.rsp_full) begin
                    w_rspWrEn = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
        endcase
    end

    // Strobes are gated by reset so nothing pops or pushes while rst is held low.
    assign bus.req_rd_en = rst && w_reqRdEn;
    assign bus.rsp_wr_en = rst && w_rspWrEn;
    assign busy          = rst && (r_state != ST_IDLE);
    assign bus.rsp_data  = (rst && r_state == ST_RESP)
                         ? {r_tid, (r_rspFromRam ? w_ramRdata : r_rspWord)}
                         : '0;
    assign req_count     = r_reqCount;
    assign wr_count      = r_wrCount;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_reqCount <= 32'd0;
            r_wrCount  <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_ramWe) begin
                r_wrCount <= r_wrCount + 32'd1;
            end
            if (w_rspWrEn) begin
                r_reqCount <= r_reqCount + 32'd1;
            end
        end
    end

    // Request fields and response-word selection; no reset needed since the FSM
    // always passes through FETCH and EXEC before these are looked at.
    always_ff @(posedge clk) begin
        if (r_state == ST_FETCH) begin
            r_tid  <= bus.req_data[TID_MSB:TID_LSB];
            r_flag <= bus.req_data[FLAG_BIT];
            r_addr <= bus.req_data[ADDR_MSB:ADDR_LSB];
            r_data <= bus.req_data[DATA_MSB:0];
        end
        if (r_state == ST_EXEC) begin
            r_rspFromRam <= !r_flag && w_inRange;
            r_rspWord    <= w_inRange ? r_data : OOR_PATTERN;
        end
    end

endmodule

// File: tb/tb_vpi_mem_responder.sv
// Directed bench for vpi_mem_responder with a small request-FIFO model and a
// negedge monitor that logs every pop and push with its cycle number.
module tb_vpi_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        busy;
    logic [31:0] reqCount;
    logic [31:0] wrCount;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vpi_mem_responder_if vif ();

    vpi_mem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (vif),
        .busy      (busy),
        .req_count (reqCount),
        .wr_count  (wrCount)
    );

    logic [79:0] fifoMem [0:63];
    int          wrPtr        = 0;
    int          rdPtr        = 0;
    bit          fakeNonEmpty = 1'b0;
    int          emptyPops    = 0;

    assign vif.req_empty = (wrPtr == rdPtr) && !fakeNonEmpty;

    // Request FIFO model: data_out becomes valid the cycle after a pop.
    always @(posedge clk) begin
        if (vif.req_rd_en) begin
            if (vif.req_empty) begin
                emptyPops <= emptyPops + 1;
            end else begin
                vif.req_data <= fifoMem[rdPtr];
                rdPtr        <= rdPtr + 1;
            end
        end
    end

    int          cycle = 0;
    logic [47:0] pushData  [0:63];
    int          pushCycle [0:63];
    int          popCycle  [0:63];
    int          pushCount = 0;
    int          popCount  = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // Monitor samples strobes mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (vif.rsp_wr_en && pushCount < 64) begin
            pushData[pushCount]  <= vif.rsp_data;
            pushCycle[pushCount] <= cycle;
            pushCount            <= pushCount + 1;
        end
        if (vif.req_rd_en && popCount < 64) begin
            popCycle[popCount] <= cycle;
            popCount           <= popCount + 1;
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic enqueue(input logic [15:0] tid, input logic wr,
                           input logic [30:0] addr, input logic [31:0] data);
        fifoMem[wrPtr] = {tid, wr, addr, data};
        wrPtr          = wrPtr + 1;
    endtask

    task automatic waitForPushes(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pushCount >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        fakeNonEmpty = 1'b1;
        vif.rsp_full = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (vif.req_rd_en !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_rd_en cycle %0d: got %b expected 0", i, vif.req_rd_en);
            end
            checks++;
            if ({busy, vif.rsp_wr_en, vif.rsp_data, reqCount, wrCount} !== 114'd0) begin
                errors++;
                $display("[TB] FAIL reset_outputs cycle %0d: busy=%b wr_en=%b rsp=%h req=%0d wr=%0d expected all 0",
                         i, busy, vif.rsp_wr_en, vif.rsp_data, reqCount, wrCount);
            end
        end
        stepCycle();
        fakeNonEmpty = 1'b0;
        rst          = 1'b1;
        checks++;
        if (popCount !== 0 || emptyPops !== 0) begin
            errors++;
            $display("[TB] FAIL reset_no_pop: got pops=%0d emptyPops=%0d expected 0/0", popCount, emptyPops);
        end
    endtask

    task automatic test_write_read();
        int pb  = pushCount;
        int pob = popCount;
        bit ok;
        enqueue(16'h0001, 1'b1, 31'd5, 32'hCAFE_0001);
        enqueue(16'h0002, 1'b0, 31'd5, 32'h0000_0000);
        waitForPushes(pb + 2, 40, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL wr_rd_timeout: got %0d pushes expected %0d", pushCount - pb, 2);
        end
        stepCycle();
        stepCycle();
        checks++;
        if (pushData[pb] !== 48'h0001_CAFE_0001) begin
            errors++;
            $display("[TB] FAIL wr_rsp: got %h expected %h", pushData[pb], 48'h0001_CAFE_0001);
        end
        checks++;
        if (pushData[pb+1] !== 48'h0002_CAFE_0001) begin
            errors++;
            $display("[TB] FAIL rd_rsp: got %h expected %h", pushData[pb+1], 48'h0002_CAFE_0001);
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (pushCycle[pb+k] - popCycle[pob+k] !== 3) begin
                errors++;
                $display("[TB] FAIL latency_%0d: got %0d expected 3", k, pushCycle[pb+k] - popCycle[pob+k]);
            end
        end
        checks++;
        if (wrCount !== 32'd1 || reqCount !== 32'd2) begin
            errors++;
            $display("[TB] FAIL wr_rd_counts: got wr=%0d req=%0d expected wr=1 req=2", wrCount, reqCount);
        end
    endtask

    task automatic test_out_of_range();
        int          pb = pushCount;
        bit          ok;
        logic [47:0] expRsp [0:3];
        expRsp[0] = 48'h00A0_1234_5678;
        expRsp[1] = 48'h00AA_DEAD_BEEF;
        expRsp[2] = 48'h00AB_DEAD_BEEF;
        expRsp[3] = 48'h00AC_1234_5678;
        enqueue(16'h00A0, 1'b1, 31'd0,          32'h1234_5678);
        enqueue(16'h00AA, 1'b0, 31'h4000_0000,  32'h0000_0000);
        enqueue(16'h00AB, 1'b1, 31'h4000_0000,  32'hFFFF_0000);
        enqueue(16'h00AC, 1'b0, 31'd0,          32'h0000_0000);
        waitForPushes(pb + 4, 60, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL oor_timeout: got %0d pushes expected 4", pushCount - pb);
        end
        stepCycle();
        stepCycle();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (pushData[pb+k] !== expRsp[k]) begin
                errors++;
                $display("[TB] FAIL oor_rsp_%0d: got %h expected %h", k, pushData[pb+k], expRsp[k]);
            end
        end
        checks++;
        if (wrCount !== 32'd2 || reqCount !== 32'd6) begin
            errors++;
            $display("[TB] FAIL oor_counts: got wr=%0d req=%0d expected wr=2 req=6", wrCount, reqCount);
        end
    endtask

    task automatic test_backpressure();
        int pb  = pushCount;
        int pob = popCount;
        bit ok;
        vif.rsp_full = 1'b1;
        enqueue(16'h00B0, 1'b0, 31'd5, 32'h0000_0000);
        repeat (3) stepCycle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (vif.rsp_wr_en !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_wr_en cycle %0d: got %b expected 0", i, vif.rsp_wr_en);
            end
            checks++;
            if (vif.rsp_data !== 48'h00B0_CAFE_0001) begin
                errors++;
                $display("[TB] FAIL bp_hold cycle %0d: got %h expected %h", i, vif.rsp_data, 48'h00B0_CAFE_0001);
            end
        end
        stepCycle();
        vif.rsp_full = 1'b0;
        waitForPushes(pb + 1, 10, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL bp_timeout: got %0d pushes expected 1", pushCount - pb);
        end
        repeat (6) stepCycle();
        checks++;
        if (pushCount !== pb + 1) begin
            errors++;
            $display("[TB] FAIL bp_single_push: got %0d pushes expected 1", pushCount - pb);
        end
        checks++;
        if (pushData[pb] !== 48'h00B0_CAFE_0001) begin
            errors++;
            $display("[TB] FAIL bp_rsp: got %h expected %h", pushData[pb], 48'h00B0_CAFE_0001);
        end
        checks++;
        if (pushCycle[pb] - popCycle[pob] !== 13) begin
            errors++;
            $display("[TB] FAIL bp_release_cycle: got %0d expected 13", pushCycle[pb] - popCycle[pob]);
        end
    endtask

    task automatic test_stream();
        int          pb = pushCount;
        bit          ok;
        logic [47:0] exp;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                enqueue(16'(i), 1'b1, 31'(i), 32'hA500_0000 | 32'(i));
            end else begin
                enqueue(16'(i), 1'b0, 31'(i - 1), 32'h0000_0000);
            end
        end
        waitForPushes(pb + 8, 80, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL stream_timeout: got %0d pushes expected 8", pushCount - pb);
        end
        for (int i = 0; i < 8; i++) begin
            exp = {16'(i), 32'hA500_0000 | 32'(i - (i % 2))};
            checks++;
            if (pushData[pb+i] !== exp) begin
                errors++;
                $display("[TB] FAIL stream_rsp_%0d: got %h expected %h", i, pushData[pb+i], exp);
            end
            if (i > 0) begin
                checks++;
                if (pushCycle[pb+i] - pushCycle[pb+i-1] !== 4) begin
                    errors++;
                    $display("[TB] FAIL stream_gap_%0d: got %0d expected 4", i, pushCycle[pb+i] - pushCycle[pb+i-1]);
                end
            end
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (vif.req_rd_en !== 1'b0) begin
                errors++;
                $display("[TB] FAIL drained_rd_en cycle %0d: got %b expected 0", i, vif.req_rd_en);
            end
        end
        stepCycle();
        checks++;
        if (emptyPops !== 0) begin
            errors++;
            $display("[TB] FAIL empty_guard: got %0d pops on empty expected 0", emptyPops);
        end
        checks++;
        if (wrCount !== 32'd6 || reqCount !== 32'd15) begin
            errors++;
            $display("[TB] FAIL stream_counts: got wr=%0d req=%0d expected wr=6 req=15", wrCount, reqCount);
        end
    endtask

    task automatic test_mid_reset();
        int pb  = pushCount;
        int pob = popCount;
        bit ok;
        enqueue(16'h00C0, 1'b1, 31'd20, 32'h5555_AAAA);
        enqueue(16'h00C1, 1'b0, 31'd5,  32'h0000_0000);
        stepCycle();
        stepCycle();
        rst = 1'b0;
        stepCycle();
        @(negedge clk);
        checks++;
        if ({busy, vif.rsp_wr_en, vif.req_rd_en} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL midrst_idle: got busy=%b wr_en=%b rd_en=%b expected 000",
                     busy, vif.rsp_wr_en, vif.req_rd_en);
        end
        checks++;
        if (reqCount !== 32'd0 || wrCount !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midrst_counts: got req=%0d wr=%0d expected 0/0", reqCount, wrCount);
        end
        stepCycle();
        rst = 1'b1;
        waitForPushes(pb + 1, 20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL midrst_timeout: got %0d pushes expected 1", pushCount - pb);
        end
        repeat (3) stepCycle();
        checks++;
        if (pushCount !== pb + 1) begin
            errors++;
            $display("[TB] FAIL midrst_push_count: got %0d expected 1", pushCount - pb);
        end
        checks++;
        if (pushData[pb] !== 48'h00C1_CAFE_0001) begin
            errors++;
            $display("[TB] FAIL midrst_rsp: got %h expected %h", pushData[pb], 48'h00C1_CAFE_0001);
        end
        checks++;
        if (pushCycle[pb] - popCycle[pob+1] !== 3) begin
            errors++;
            $display("[TB] FAIL midrst_latency: got %0d expected 3", pushCycle[pb] - popCycle[pob+1]);
        end
        checks++;
        if (reqCount !== 32'd1 || wrCount !== 32'd0) begin
            errors++;
            $display("[TB] FAIL midrst_after_counts: got req=%0d wr=%0d expected 1/0", reqCount, wrCount);
        end
    endtask

    initial begin
        vif.rsp_full = 1'b0;
        test_reset();
        test_write_read();
        test_out_of_range();
        test_backpressure();
        test_stream();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
